// File: rtl/rfalu_pkg.sv
// Shared constants and types for the register-file/ALU sequencer.
// Optional R-type add decode is enabled with the RFALU_RTYPE_EN macro.
package rfalu_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] ALU_ADD = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    // Instruction class as seen by the sequencer; INS_ADD is only produced
    // when R-type decode is built in.
    typedef enum logic [1:0] {
        INS_BAD  = 2'd0,
        INS_ADDI = 2'd1,
        INS_BNE  = 2'd2,
        INS_ADD  = 2'd3
    } ins_kind_t;

endpackage

// File: rtl/rfalu_sequencer_if.sv
// Instruction-memory and datapath bundle between the sequencer (master)
// and the register-file/ALU datapath plus instruction memory (slave).
interface rfalu_sequencer_if #(
    parameter int WIDTH        = 32,
    parameter int rWIDTH       = 5,
    parameter int aluctrlWIDTH = 3,
    parameter int IMEM_AW      = 8
);
    logic [IMEM_AW-1:0]      imem_addr;
    logic [31:0]             imem_rdata;
    logic                    EQ;
    logic [rWIDTH-1:0]       AD1;
    logic [rWIDTH-1:0]       AD2;
    logic [rWIDTH-1:0]       AD3;
    logic                    RegWrite;
    logic [aluctrlWIDTH-1:0] ALUctrl;
    logic                    ALUsrc;
    logic [WIDTH-1:0]        ImmOp;

    modport master (
        output imem_addr, AD1, AD2, AD3, RegWrite, ALUctrl, ALUsrc, ImmOp,
        input  imem_rdata, EQ
    );

    modport slave (
        input  imem_addr, AD1, AD2, AD3, RegWrite, ALUctrl, ALUsrc, ImmOp,
        output imem_rdata, EQ
    );
endinterface

// File: rtl/rv_imm_gen.sv
// Immediate generator: sign-extended I-type for OP-IMM, B-type for BRANCH,
// zero for everything else (including R-type, which carries no immediate).
module rv_imm_gen
    import rfalu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] imm
);

    // rs1/funct3 bits carry no immediate information in either format
    logic unused_fields;
    assign unused_fields = ^instr[19:12];

    // Select the immediate layout from the opcode
    always_comb begin
        imm = '0;
        case (instr[6:0])
            OP_IMM:    imm = {{(WIDTH-12){instr[31]}}, instr[31:20]};
            OP_BRANCH: imm = {{(WIDTH-13){instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0};
            OP_REG:    imm = '0;
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/rfalu_sequencer.sv
// Two-cycle-per-instruction sequencer for the register-file/ALU datapath.
// Fetches from a synchronous-read instruction memory, decodes addi and bne
// (plus R-type add when RFALU_RTYPE_EN is defined) and resolves branches
// from the datapath EQ flag.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | imem address presented, instruction arrives next cycle
// EXEC  | instruction decoded onto datapath, PC updated at end of cycle
// HALT  | stopped after an illegal instruction or misaligned branch
module rfalu_sequencer
    import rfalu_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               rWIDTH       = 5,
    parameter int               aluctrlWIDTH = 3,
    parameter int               IMEM_AW      = 8,
    parameter logic [WIDTH-1:0] RESET_PC     = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    rfalu_sequencer_if.master  bus,
    output logic [WIDTH-1:0]   pc,
    output logic               busy,
    output logic               halted,
    output logic               illegal
);

    seq_state_t       state;
    ins_kind_t        kind;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] br_tgt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;

    assign opcode = bus.imem_rdata[6:0];
    assign funct3 = bus.imem_rdata[14:12];

    rv_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr (bus.imem_rdata),
        .imm   (imm)
    );

    assign pc_inc        = pc + WIDTH'(4);
    assign br_tgt        = pc + imm;
    assign bus.imem_addr = pc[IMEM_AW+1:2];

    // Classify the fetched word; anything unrecognised is INS_BAD
    always_comb begin
        kind = INS_BAD;
        if (opcode == OP_IMM && funct3 == F3_ADD) begin
            kind = INS_ADDI;
        end else if (opcode == OP_BRANCH && funct3 == F3_BNE) begin
            kind = INS_BNE;
        end
`ifdef RFALU_RTYPE_EN
        else if (opcode == OP_REG && funct3 == F3_ADD &&
                 bus.imem_rdata[31:25] == 7'b0000000) begin
            kind = INS_ADD;
        end
`endif
    end

    // Datapath controls: decode only in EXEC so RegWrite cannot leak into
    // FETCH/IDLE/HALT, and an async reset drops it immediately via state
    always_comb begin
        bus.AD1      = '0;
        bus.AD2      = '0;
        bus.AD3      = '0;
        bus.RegWrite = 1'b0;
        bus.ALUctrl  = aluctrlWIDTH'(ALU_ADD);
        bus.ALUsrc   = 1'b0;
        bus.ImmOp    = '0;
        if (state == EXEC) begin
            case (kind)
                INS_ADDI: begin
                    bus.AD1      = rWIDTH'(bus.imem_rdata[19:15]);
                    bus.AD3      = rWIDTH'(bus.imem_rdata[11:7]);
                    bus.ALUsrc   = 1'b1;
                    bus.ImmOp    = imm;
                    bus.RegWrite = (bus.imem_rdata[11:7] != 5'd0);
                end
                INS_BNE: begin
                    bus.AD1   = rWIDTH'(bus.imem_rdata[19:15]);
                    bus.AD2   = rWIDTH'(bus.imem_rdata[24:20]);
                    bus.ImmOp = imm;
                end
                INS_ADD: begin
                    bus.AD1      = rWIDTH'(bus.imem_rdata[19:15]);
                    bus.AD2      = rWIDTH'(bus.imem_rdata[24:20]);
                    bus.AD3      = rWIDTH'(bus.imem_rdata[11:7]);
                    bus.RegWrite = (bus.imem_rdata[11:7] != 5'd0);
                end
                default: ;
            endcase
        end
    end

    // Sequencer FSM with PC update and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            illegal <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= EXEC;
                end
                EXEC: begin
                    case (kind)
                        INS_ADDI, INS_ADD: begin
                            pc    <= pc_inc;
                            state <= FETCH;
                        end
                        INS_BNE: begin
                            if (bus.EQ) begin
                                pc    <= pc_inc;
                                state <= FETCH;
                            end else if (br_tgt[1]) begin
                                // taken to a non-word address: stop, keep pc
                                illegal <= 1'b1;
                                state   <= HALT;
                                busy    <= 1'b0;
                                halted  <= 1'b1;
                            end else begin
                                pc    <= br_tgt;
                                state <= FETCH;
                            end
                        end
                        default: begin
                            illegal <= 1'b1;
                            state   <= HALT;
                            busy    <= 1'b0;
                            halted  <= 1'b1;
                        end
                    endcase
                end
                HALT: ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rfalu_sequencer.sv
// Self-checking bench for rfalu_sequencer: directed scenarios with literal
// expectations plus randomized programs checked every cycle against an
// instruction-level model.
module tb_rfalu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        eq = 1'b0;
    logic [31:0] pc;
    logic        busy, halted, illegal;
    logic [31:0] mem [256];
    logic [31:0] rdata_q;

    int total = 0;
    int bad = 0;

    rfalu_sequencer_if bus ();

    rfalu_sequencer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bus     (bus.master),
        .pc      (pc),
        .busy    (busy),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata_q <= mem[bus.imem_addr];
    assign bus.imem_rdata = rdata_q;
    assign bus.EQ = eq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected instruction effect derived from the encoding rules
    typedef struct packed {
        logic [1:0]  kind;   // 0 illegal, 1 addi, 2 bne, 3 add
        logic [4:0]  a1, a2, a3;
        logic        rw, src;
        logic [31:0] imm;
    } exp_t;

    function automatic exp_t decode(input logic [31:0] i);
        exp_t e;
        e = '0;
        if (i[6:0] == 7'h13 && i[14:12] == 3'd0) begin
            e.kind = 2'd1; e.a1 = i[19:15]; e.a3 = i[11:7];
            e.rw = (i[11:7] != 0); e.src = 1'b1;
            e.imm = 32'($signed(i[31:20]));
        end else if (i[6:0] == 7'h63 && i[14:12] == 3'd1) begin
            e.kind = 2'd2; e.a1 = i[19:15]; e.a2 = i[24:20];
            e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        end
`ifdef RFALU_RTYPE_EN
        else if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'd0) begin
            e.kind = 2'd3; e.a1 = i[19:15]; e.a2 = i[24:20]; e.a3 = i[11:7];
            e.rw = (i[11:7] != 0);
        end
`endif
        return e;
    endfunction

    // Model: mode 0 idle, 1 fetching, 2 executing, 3 halted
    int          m_mode = 0;
    logic [31:0] m_pc = 32'h0;
    logic        m_ill = 1'b0;

    always @(negedge clk) begin
        exp_t        d;
        exp_t        e;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_mode = 0; m_pc = 32'h0; m_ill = 1'b0;
        end
        d = decode(mem[m_pc[9:2]]);
        e = (m_mode == 2 && d.kind != 2'd0) ? d : '0;
        chk("pc", pc, m_pc);
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc[9:2]));
        chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
        chk("halted", 32'(halted), 32'(m_mode == 3));
        chk("illegal", 32'(illegal), 32'(m_ill));
        chk("AD1", 32'(bus.AD1), 32'(e.a1));
        chk("AD2", 32'(bus.AD2), 32'(e.a2));
        chk("AD3", 32'(bus.AD3), 32'(e.a3));
        chk("RegWrite", 32'(bus.RegWrite), 32'(e.rw));
        chk("ALUsrc", 32'(bus.ALUsrc), 32'(e.src));
        chk("ALUctrl", 32'(bus.ALUctrl), 32'h0);
        chk("ImmOp", bus.ImmOp, e.imm);
        if (rst_n) begin
            case (m_mode)
                0: if (start) m_mode = 1;
                1: m_mode = 2;
                2: begin
                    tgt = m_pc + d.imm;
                    if (d.kind == 2'd1 || d.kind == 2'd3) begin
                        m_pc = m_pc + 4; m_mode = 1;
                    end else if (d.kind == 2'd2) begin
                        if (eq) begin
                            m_pc = m_pc + 4; m_mode = 1;
                        end else if (tgt[1]) begin
                            m_ill = 1'b1; m_mode = 3;
                        end else begin
                            m_pc = tgt; m_mode = 1;
                        end
                    end else begin
                        m_ill = 1'b1; m_mode = 3;
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0; start = 1'b0; eq = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic release_reset();
        step(); step();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] rand_ins();
        int          s;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] i12;
        logic [12:0] b;
        s   = $urandom_range(0, 11);
        rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        i12 = 12'($urandom);
        b   = 13'($urandom_range(0, 63) * 2 - 64);
        if (s <= 4) return {i12, rs1, 3'b000, rd, 7'b0010011};
        if (s <= 8) return {b[12], b[10:5], rs2, rs1, 3'b001, b[4:1], b[11], 7'b1100011};
        if (s == 9) return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
        if (s == 10) return {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
        return $urandom;
    endfunction

    initial begin
        // reset state and the reference program
        hold_reset();
        mem[0] = 32'h00500513;
        mem[1] = 32'hFFF00093;
        mem[2] = 32'hFE009EE3;
        mem[3] = 32'h002081B3;
        release_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_regwrite", 32'(bus.RegWrite), 32'h0);
        start = 1'b1; step(); start = 1'b0;
        chk("fetch_busy", 32'(busy), 32'h1);
        step();
        chk("addi_ad1", 32'(bus.AD1), 32'd0);
        chk("addi_ad3", 32'(bus.AD3), 32'd10);
        chk("addi_src", 32'(bus.ALUsrc), 32'd1);
        chk("addi_imm", bus.ImmOp, 32'd5);
        chk("addi_rw", 32'(bus.RegWrite), 32'd1);
        step();
        chk("addi_pc", pc, 32'd4);
        chk("addi_rw_off", 32'(bus.RegWrite), 32'd0);
        step();
        chk("neg_imm", bus.ImmOp, 32'hFFFFFFFF);
        chk("neg_ad3", 32'(bus.AD3), 32'd1);
        chk("neg_rw", 32'(bus.RegWrite), 32'd1);
        step(); eq = 1'b0;
        step();
        chk("bne_imm", bus.ImmOp, 32'hFFFFFFFC);
        chk("bne_ad1", 32'(bus.AD1), 32'd1);
        chk("bne_rw", 32'(bus.RegWrite), 32'd0);
        step();
        chk("bne_taken_pc", pc, 32'd4);
        step(); step(); eq = 1'b1;
        step();
        chk("bne_nt_rw", 32'(bus.RegWrite), 32'd0);
        step();
        chk("bne_nt_pc", pc, 32'd12);
        step();
`ifdef RFALU_RTYPE_EN
        chk("add_ad1", 32'(bus.AD1), 32'd1);
        chk("add_ad2", 32'(bus.AD2), 32'd2);
        chk("add_ad3", 32'(bus.AD3), 32'd3);
        chk("add_src", 32'(bus.ALUsrc), 32'd0);
        chk("add_rw", 32'(bus.RegWrite), 32'd1);
        step(); step(); step();
        chk("add_halt_pc", pc, 32'd16);
`else
        chk("add_ill_rw", 32'(bus.RegWrite), 32'd0);
        step();
        chk("add_halt_pc", pc, 32'd12);
`endif
        chk("add_illegal", 32'(illegal), 32'd1);
        chk("add_halted", 32'(halted), 32'd1);

        // illegal word at pc=4, start ignored afterwards
        hold_reset();
        mem[0] = 32'h00500513;
        release_reset();
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        chk("ill_rw", 32'(bus.RegWrite), 32'd0);
        step();
        chk("ill_pc", pc, 32'd4);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_halted", 32'(halted), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        start = 1'b1; step(); step(); step(); start = 1'b0;
        chk("ill_sticky_pc", pc, 32'd4);
        chk("ill_sticky_halted", 32'(halted), 32'd1);

        // misaligned taken branch (bne x1,x0,+2), then the same not taken
        hold_reset();
        mem[0] = 32'h00009163;
        release_reset();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        chk("mis_pc", pc, 32'd0);
        chk("mis_illegal", 32'(illegal), 32'd1);
        hold_reset();
        mem[0] = 32'h00009163;
        release_reset();
        eq = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        chk("mis_nt_pc", pc, 32'd4);
        chk("mis_nt_illegal", 32'(illegal), 32'd0);

        // PC wrap below zero and aliasing of imem_addr
        hold_reset();
        mem[0]   = 32'hFE009EE3;
        mem[255] = 32'h00100093;
        release_reset();
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        chk("wrap_pc", pc, 32'hFFFFFFFC);
        chk("wrap_addr", 32'(bus.imem_addr), 32'hFF);
        step(); step();
        chk("wrap_pc0", pc, 32'h0);

        // asynchronous reset in the middle of EXEC
        hold_reset();
        mem[0] = 32'h00500513;
        release_reset();
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("mid_rw_before", 32'(bus.RegWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rw_after", 32'(bus.RegWrite), 32'd0);
        chk("mid_pc", pc, 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        step(); rst_n = 1'b1;
        step(); step(); step();
        chk("mid_wait_busy", 32'(busy), 32'd0);
        start = 1'b1; step(); start = 1'b0;
        chk("mid_restart_busy", 32'(busy), 32'd1);

        // randomized programs with random EQ and stray start pulses
        for (int run = 0; run < 24; run++) begin
            hold_reset();
            for (int i = 0; i < 256; i++) mem[i] = rand_ins();
            release_reset();
            for (int c = 0; c < 60; c++) begin
                start = ($urandom_range(0, 3) == 0);
                eq    = 1'($urandom);
                step();
            end
        end

        start = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
